// File: rtl/led2hex_capture.sv
// led2hex_capture: samples a multiplexed active-low 4-digit 7-segment bus and rebuilds the hex nibble on each digit
// Ports: CLK clock; RESET async active-high; LED[6:0] active-low segments; AN[3:0] active-low digit enables;
//        HEX[15:0] nibble per digit; VALID[3:0] nibble current and legal; UPD pulse on nibble change;
//        ERR pulse on illegal pattern; ERR_DIG digit of the last ERR.
module led2hex_capture #(
  parameter int STABLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  LED,
  input  logic [3:0]  AN,
  output logic [15:0] HEX,
  output logic [3:0]  VALID,
  output logic        UPD,
  output logic        ERR,
  output logic [1:0]  ERR_DIG
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int AW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
  state_t state, state_nx;
  logic [10:0] s1, s2, s3;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] age [4];
  logic [3:0] na, nib;
  logic [1:0] dig;
  logic one_hot, changed, legal, blank;
  assign changed = s2 != s3;
  assign one_hot = $onehot(~s2[10:7]);
  assign cnt_nx = changed ? '0 : (cnt == CW'(STABLE_CYC) ? cnt : cnt + 1'b1);
  // capture reads s3: it holds the value that completed the stable window even if s2 moves on that edge
  assign na = ~s3[10:7];
  assign dig = {na[3] | na[2], na[3] | na[1]};
  assign blank = s3[6:0] == 7'b1111111;
  always_comb begin
    legal = 1'b1;
    nib = 4'h0;
    case (s3[6:0])
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      default:    legal = 1'b0;
    endcase
  end
  // leaving CAPTURE must also notice a change that landed during the capture cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:          state_nx = one_hot ? SETTLE : IDLE;
      SETTLE:        state_nx = !one_hot ? IDLE : cnt_nx == CW'(STABLE_CYC) ? CAPTURE : SETTLE;
      CAPTURE, HOLD: state_nx = !changed ? HOLD : one_hot ? SETTLE : IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
      cnt <= '0;
      state <= IDLE;
      HEX <= '0;
      VALID <= '0;
      UPD <= 1'b0;
      ERR <= 1'b0;
      ERR_DIG <= '0;
      for (int i = 0; i < 4; i++) age[i] <= '0;
    end else begin
      s1 <= {AN, LED};
      s2 <= s1;
      s3 <= s2;
      cnt <= cnt_nx;
      state <= state_nx;
      UPD <= 1'b0;
      ERR <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        age[i] <= age[i] == AW'(TIMEOUT_CYC) ? age[i] : age[i] + 1'b1;
        if (age[i] == AW'(TIMEOUT_CYC - 1)) VALID[i] <= 1'b0;
      end
      // later writes below override the timeout path, so a capture wins over a same-cycle timeout
      if (state == CAPTURE) begin
        if (legal || blank) age[dig] <= '0;
        if (legal) begin
          HEX[4*dig +: 4] <= nib;
          VALID[dig] <= 1'b1;
          UPD <= nib != HEX[4*dig +: 4] || !VALID[dig];
        end else begin
          VALID[dig] <= 1'b0;
          ERR <= !blank;
          if (!blank) ERR_DIG <= dig;
        end
      end
    end
  end
endmodule
